// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the CPU and the loader.
// Optional loader burst lock is compiled in with `define MEM_ARBITER_LOCK_EN.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_lock,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RDWAIT = 2'd2} state_e;
    typedef enum logic {OWN_CPU = 1'b0, OWN_LD = 1'b1} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_gnt_q, last_gnt_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                cpu_gnt_q, cpu_gnt_d;
    logic                ld_gnt_q, ld_gnt_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   ld_rdata_q, ld_rdata_d;
    logic                arb_now_s;
    logic                arb_ld_s;
    logic                cpu_rvalid_s;
    logic                ld_rvalid_s;

`ifndef MEM_ARBITER_LOCK_EN
    logic unused_lock_s;
    assign unused_lock_s = ld_lock;
`endif

    // Winner selection: single requester wins, ties go to whoever was not granted last.
    always_comb begin
        if (cpu_req && ld_req) begin
            arb_ld_s = (last_gnt_q == OWN_CPU);
        end else begin
            arb_ld_s = ld_req;
        end
`ifdef MEM_ARBITER_LOCK_EN
        // A locked burst keeps the memory while the loader keeps requesting.
        if (ld_lock && ld_req && (last_gnt_q == OWN_LD)) begin
            arb_ld_s = 1'b1;
        end else begin
            arb_ld_s = arb_ld_s;
        end
`endif
    end

    // Read-return path: owner sees memory data during RDWAIT, the other side holds its last value.
    always_comb begin
        cpu_rvalid_s = (state_q == RDWAIT) && (owner_q == OWN_CPU);
        ld_rvalid_s  = (state_q == RDWAIT) && (owner_q == OWN_LD);
        cpu_rdata_d  = cpu_rvalid_s ? mem_rdata : cpu_rdata_q;
        ld_rdata_d   = ld_rvalid_s ? mem_rdata : ld_rdata_q;
    end

    // Next-state and registered memory/grant outputs.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_gnt_d  = last_gnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_gnt_d   = 1'b0;
        ld_gnt_d    = 1'b0;
        arb_now_s   = 1'b0;
        case (state_q)
            IDLE:    arb_now_s = 1'b1;
            ISSUE: begin
                if (mem_we_q) begin
                    arb_now_s = 1'b1;
                end else begin
                    state_d = RDWAIT;
                end
            end
            RDWAIT:  arb_now_s = 1'b1;
            default: state_d = IDLE;
        endcase
        if (arb_now_s) begin
            if (cpu_req || ld_req) begin
                state_d     = ISSUE;
                mem_en_d    = 1'b1;
                mem_we_d    = arb_ld_s ? ld_we : cpu_we;
                mem_addr_d  = arb_ld_s ? ld_addr : cpu_addr;
                mem_wdata_d = arb_ld_s ? ld_wdata : cpu_wdata;
                owner_d     = arb_ld_s ? OWN_LD : OWN_CPU;
                last_gnt_d  = arb_ld_s ? OWN_LD : OWN_CPU;
                cpu_gnt_d   = ~arb_ld_s;
                ld_gnt_d    = arb_ld_s;
            end else begin
                state_d = IDLE;
            end
        end else begin
            arb_now_s = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    // State registers; asynchronous reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            last_gnt_q  <= OWN_LD;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            cpu_gnt_q   <= 1'b0;
            ld_gnt_q    <= 1'b0;
            busy_q      <= 1'b0;
            cpu_rdata_q <= {DATA_W{1'b0}};
            ld_rdata_q  <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_gnt_q  <= last_gnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_gnt_q   <= cpu_gnt_d;
            ld_gnt_q    <= ld_gnt_d;
            busy_q      <= busy_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign ld_gnt     = ld_gnt_q;
    assign cpu_rvalid = cpu_rvalid_s;
    assign ld_rvalid  = ld_rvalid_s;
    assign cpu_rdata  = cpu_rdata_d;
    assign ld_rdata   = ld_rdata_d;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port program/data memory between two requesters: the CPU datapath (fetch, LOAD, STORE) and the program loader/debug port.
- Sits between the control-unit-driven address/data muxes and the memory macro.
- Serialises accesses to one outstanding transaction, arbitrates round-robin, and returns read data with a valid strobe so the CPU FSM can stall in FETCH/MEMORY until data arrives.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, held until cpu_gnt.
- cpu_we  in  1  1 = write (STORE), 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  one-cycle pulse; access issued this cycle.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid.
- cpu_rdata  out  DATA_W  read data.
- ld_req  in  1  loader request, held until ld_gnt.
- ld_we  in  1  loader write enable.
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write data.
- ld_lock  in  1  loader burst lock; only used with the optional feature.
- ld_gnt  out  1  loader grant pulse.
- ld_rvalid  out  1  loader read-valid pulse.
- ld_rdata  out  DATA_W  read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  synchronous memory read data, valid 1 cycle after mem_en with mem_we = 0.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: all outputs 0. State IDLE, owner = CPU, last_gnt = LD (so the CPU wins the first tie).
- Reset is asynchronous and acts mid-transaction. mem_en and mem_we drop immediately, any pending rvalid is discarded, and the state returns to IDLE.
- States are IDLE, ISSUE and RDWAIT.
- Arbitration is evaluated in IDLE, at the end of an ISSUE-write, and at the end of RDWAIT:
  - only one requester asserted -> it wins;
  - both asserted -> grant the one not equal to last_gnt (round-robin);
  - neither asserted -> go to or stay in IDLE.
- On the winning edge, next state is ISSUE:
  - mem_en, mem_we, mem_addr and mem_wdata are registered from the winner's inputs;
  - owner and last_gnt are updated;
  - the winner's gnt is high for exactly this ISSUE cycle.
- ISSUE with mem_we = 1: the write completes at the end of the cycle. Re-arbitrate, giving back-to-back ISSUE with no bubble if any request is pending, otherwise go to IDLE.
- ISSUE with mem_we = 0: next state is RDWAIT with mem_en = 0.
- RDWAIT: <owner>_rvalid = 1 and <owner>_rdata = mem_rdata (combinational pass-through) for this one cycle, then re-arbitrate.
- The non-owner's rvalid stays 0, and its rdata holds its last valid value (registered capture on rvalid).
- Latency from req asserted in IDLE:
  - gnt at +1 cycle;
  - write lands in memory at the +1 edge+1;
  - rvalid at +2.
- Throughput: one write per cycle, one read per 2 cycles.
- Requester rules:
  - Requester inputs are sampled only on the granting edge.
  - A request dropped before its grant is lost; this is not an error.
  - A requester may reassert req in the cycle after gnt; the request is then subject to round-robin.
- mem_en is never high in two cycles where the first is a read.
- Exactly one gnt may be high per cycle.

Optional Feature:
- Macro: MEM_ARBITER_LOCK_EN.
- Defined: while ld_lock = 1 and the last grant went to LD, ld_req wins every arbitration regardless of cpu_req. Burst loads run back-to-back and the CPU stalls. The lock is released on the first arbitration where ld_lock = 0 or ld_req = 0; normal round-robin resumes, so the CPU wins if it is requesting.
- Undefined: ld_lock is ignored; pure round-robin.

Test Plan:
- Reset, then CPU read: cpu_req = 1, cpu_addr = 0x05, mem holds 0x3C at 0x05.
  -> cpu_gnt at cycle 1 with mem_en = 1, mem_we = 0, mem_addr = 0x05; cpu_rvalid at cycle 2 with cpu_rdata = 0x3C; ld_* outputs stay 0.
- Loader writes back-to-back: ld_we = 1 to addresses 0x00, 0x01, 0x02 with data 0xA1, 0xA2, 0xA3, CPU idle.
  -> three consecutive ISSUE cycles with no bubble; memory reads back 0xA1, 0xA2, 0xA3.
- Contention: cpu_req and ld_req both held from the cycle after reset.
  -> grants alternate CPU, LD, CPU, LD; never two gnt in one cycle.
- Reset mid-read: cpu read issued, reset_n = 0 during RDWAIT.
  -> cpu_rvalid never pulses; all outputs 0 immediately; after release, a new ld_req is granted at +1 cycle.
- Lock, with MEM_ARBITER_LOCK_EN defined: ld_lock = 1, 4 loader writes, cpu_req held.
  -> 4 ld_gnt pulses, then cpu_gnt on the arbitration after ld_lock falls. With the macro undefined, grants alternate instead.
